bit8_to_trit5_unpack: RTL and testbench
=======================================

Name: bit8_to_trit5_unpack

Overview:
Sequential S3 unpacker for the hash/decaps datapath. It takes a stream of packed bytes, each holding 5 trits in base 3 (trit0 least significant), and emits one trit per cycle in index order. It is the receive-side counterpart of the trit5-to-bit8 packing path. It rebuilds a polynomial of N_TRITS trits for the S3 arithmetic units.

Parameters:
N_TRITS, 700, trits per polynomial (140 bytes × 5; need not be a multiple of 5).
IDX_W, 10, width of trit_idx; must satisfy 2^IDX_W > N_TRITS.

Ports:
clk  input  1  clock, rising edge.
ovr_rst  input  1  reset, asynchronous, active-high.
start  input  1  begin a new polynomial; honoured only in IDLE.
in_byte  input  8  packed byte.
in_valid  input  1  in_byte is valid.
in_ready  output  1  unpacker accepts a byte this cycle.
trit  output  2  trit value: 00=0, 01=1, 10=2; 11 is never driven.
trit_valid  output  1  trit/trit_idx/last are valid.
trit_ready  input  1  consumer accepts the trit.
trit_idx  output  IDX_W  index of the current trit (0..N_TRITS-1).
last  output  1  current trit is index N_TRITS-1.
busy  output  1  high in any state other than IDLE.
done  output  1  one-cycle pulse after the last trit is accepted.
err  output  1  sticky malformed-byte flag (see Optional Feature).

Behaviour:
- Reset: state=IDLE. The following are 0: in_ready, trit_valid, trit, trit_idx, last, busy, done, err. Internal residue r=0 and digit count k=0. Reset takes effect immediately at any point, including mid-polynomial, and discards any partial byte.
- States: IDLE, LOAD, EMIT, DONE.
- IDLE: on start=1, trit_idx<=0 and state goes to LOAD. Otherwise the block holds.
- LOAD: in_ready=1 (registered, driven high for the whole state). When in_valid&in_ready: r<=in_byte, k<=0, state goes to EMIT. The first trit of the byte is valid on the next cycle (latency 1).
- EMIT: trit = r mod 3 (combinational from the registered r), trit_valid=1, in_ready=0. A transfer happens when trit_valid&trit_ready. On transfer: r<=r/3 (8-bit integer divide), k<=k+1, trit_idx<=trit_idx+1.
  - If trit_idx==N_TRITS-1: go to DONE.
  - Else if k==4: go to LOAD.
  - Else: stay in EMIT.
- Backpressure: while trit_ready=0, trit, trit_idx, r and k hold stable. trit_valid never drops without a transfer.
- Partial final byte: when N_TRITS mod 5 ≠ 0, the last byte yields only the remaining trits. Its unused high digits are discarded without check.
- DONE: done=1 for exactly one cycle, then IDLE. trit_idx resets to 0 on the next start.
- start while busy is ignored. start together with in_valid in IDLE: the byte is not taken; it is accepted in LOAD on the next cycle.
- Throughput: 5 trits per 6 cycles with no backpressure.
- Byte values 243..255: the decode equals the 5 base-3 digits of (byte mod 243). The repeated divide yields this naturally, and the 5th digit is taken mod 3.

Optional Feature:
Macro S3_UNPACK_CHECK_EN.
- Defined: when a byte > 242 is accepted in LOAD, err<=1 on that edge. err stays high until the next accepted start or reset. Decoding is unchanged.
- Not defined: no comparator is built; err is tied to 0.

Test Plan:
1. Set N_TRITS=10, start, bytes 0x00 then 0xF2 (242) with trit_ready=1. Required: trits 0,0,0,0,0,2,2,2,2,2, idx 0..9, last on idx 9, done pulse one cycle after, then IDLE.
2. Byte 100. Required: trits 1,0,2,0,1. First trit_valid one cycle after acceptance; in_ready high again in the cycle after trit 4 transfers.
3. Backpressure: toggle trit_ready 1,0,0,1,... on byte 100. Required: trit/idx held during stalls, no lost or duplicated trits, sequence still 1,0,2,0,1.
4. N_TRITS=7, bytes 100 and 5. Required: 1,0,2,0,1,2,1, then DONE. The second byte's upper 3 digits are not emitted. in_ready stays 0 after byte 2.
5. Byte 250 (≡7). Required: trits 1,2,0,0,0. With S3_UNPACK_CHECK_EN, err=1 from the acceptance edge until the next start. Without the macro, err=0 throughout.
6. Assert ovr_rst after trit idx 3 of the default 700-trit run. Required: all outputs 0 and IDLE immediately. A new start then decodes from idx 0 correctly.

Source files
------------

// File: rtl/bit8_to_trit5_unpack.sv
// Receive-side S3 unpacker: each accepted byte holds 5 base-3 digits (trit0 least significant),
// emitted one trit per cycle in index order. Define S3_UNPACK_CHECK_EN to flag bytes above 242 on err.
module bit8_to_trit5_unpack #(
  parameter int N_TRITS = 700,
  parameter int IDX_W   = 10
) (
  input  logic             clk,
  input  logic             ovr_rst,
  input  logic             start,
  input  logic [7:0]       in_byte,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [1:0]       trit,
  output logic             trit_valid,
  input  logic             trit_ready,
  output logic [IDX_W-1:0] trit_idx,
  output logic             last,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_EMIT = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_TRITS - 1);

  if ((64'd1 << IDX_W) <= 64'(N_TRITS)) begin : g_bad_idx_w
    $error("IDX_W too narrow for N_TRITS");
  end

  logic [1:0]       state_q, state_d;
  logic [7:0]       r_q, r_d;
  logic [2:0]       k_q, k_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             in_ready_q, in_ready_d;

  logic       byte_take;
  logic       trit_xfer;
  logic [7:0] r_mod3;

  assign byte_take = (state_q == ST_LOAD) && in_valid && in_ready_q;
  assign trit_xfer = (state_q == ST_EMIT) && trit_ready;
  assign r_mod3    = r_q % 8'd3;

  // NOTE: every signal gets a default at the top of an always_comb so no path leaves
  // it unassigned; that is what keeps this block from inferring latches.
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    k_d     = k_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          idx_d   = '0;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (byte_take) begin
          r_d     = in_byte;
          k_d     = 3'd0;
          state_d = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (trit_xfer) begin
          // Repeated divide by 3 peels digits LSB first; for bytes 243..255 the
          // fifth digit comes out as 3 and is reduced by the mod on the output.
          r_d   = r_q / 8'd3;
          k_d   = k_q + 3'd1;
          idx_d = idx_q + IDX_W'(1);
          if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
          end else if (k_q == 3'd4) begin
            state_d = ST_LOAD;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    in_ready_d = (state_d == ST_LOAD);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample the
  // pre-edge values together; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge ovr_rst) begin
    if (ovr_rst) begin
      state_q    <= ST_IDLE;
      r_q        <= 8'd0;
      k_q        <= 3'd0;
      idx_q      <= '0;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      r_q        <= r_d;
      k_q        <= k_d;
      idx_q      <= idx_d;
      in_ready_q <= in_ready_d;
    end
  end

`ifdef S3_UNPACK_CHECK_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if ((state_q == ST_IDLE) && start) begin
      err_d = 1'b0;
    end else if (byte_take && (in_byte > 8'd242)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge ovr_rst) begin
    if (ovr_rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign in_ready   = in_ready_q;
  assign trit_valid = (state_q == ST_EMIT);
  assign trit       = trit_valid ? r_mod3[1:0] : 2'd0;
  assign trit_idx   = idx_q;
  assign last       = trit_valid && (idx_q == LAST_IDX);
  assign busy       = (state_q != ST_IDLE);
  assign done       = (state_q == ST_DONE);

endmodule

// File: tb/tb_bit8_to_trit5_unpack.sv
// Scoreboard bench for bit8_to_trit5_unpack: three instances (10, 7 and 700 trits) share the
// byte/ready inputs; a monitor pops hand-computed expected trits whenever a trit transfers.
module tb_bit8_to_trit5_unpack;

  localparam int IDX_W = 10;
`ifdef S3_UNPACK_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  typedef struct packed {
    logic [1:0]       trit;
    logic [IDX_W-1:0] idx;
    logic             last;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             ovr_rst;
  logic [7:0]       in_byte;
  logic             in_valid;
  logic             trit_ready;
  logic             start_v      [3];
  logic             in_ready_v   [3];
  logic [1:0]       trit_v       [3];
  logic             trit_valid_v [3];
  logic [IDX_W-1:0] trit_idx_v   [3];
  logic             last_v       [3];
  logic             busy_v       [3];
  logic             done_v       [3];
  logic             err_v        [3];

  int   sel;
  int   n_checks = 0;
  int   n_err    = 0;
  exp_t exp_q[$];
  int   seq[10];

  bit8_to_trit5_unpack #(.N_TRITS(10), .IDX_W(IDX_W)) u_dut10 (
    .clk(clk), .ovr_rst(ovr_rst), .start(start_v[0]), .in_byte(in_byte), .in_valid(in_valid),
    .in_ready(in_ready_v[0]), .trit(trit_v[0]), .trit_valid(trit_valid_v[0]),
    .trit_ready(trit_ready), .trit_idx(trit_idx_v[0]), .last(last_v[0]), .busy(busy_v[0]),
    .done(done_v[0]), .err(err_v[0])
  );

  bit8_to_trit5_unpack #(.N_TRITS(7), .IDX_W(IDX_W)) u_dut7 (
    .clk(clk), .ovr_rst(ovr_rst), .start(start_v[1]), .in_byte(in_byte), .in_valid(in_valid),
    .in_ready(in_ready_v[1]), .trit(trit_v[1]), .trit_valid(trit_valid_v[1]),
    .trit_ready(trit_ready), .trit_idx(trit_idx_v[1]), .last(last_v[1]), .busy(busy_v[1]),
    .done(done_v[1]), .err(err_v[1])
  );

  bit8_to_trit5_unpack #(.N_TRITS(700), .IDX_W(IDX_W)) u_dut700 (
    .clk(clk), .ovr_rst(ovr_rst), .start(start_v[2]), .in_byte(in_byte), .in_valid(in_valid),
    .in_ready(in_ready_v[2]), .trit(trit_v[2]), .trit_valid(trit_valid_v[2]),
    .trit_ready(trit_ready), .trit_idx(trit_idx_v[2]), .last(last_v[2]), .busy(busy_v[2]),
    .done(done_v[2]), .err(err_v[2])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every transfer against the queue head and checks stall stability.
  initial begin
    logic             stall;
    logic [1:0]       held_trit;
    logic [IDX_W-1:0] held_idx;
    exp_t             e;
    stall = 1'b0;
    forever begin
      @(negedge clk);
      if (ovr_rst) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          check("hold", {29'd0, trit_valid_v[sel], trit_v[sel]}, {29'd0, 1'b1, held_trit});
          check("hold_idx", 32'(trit_idx_v[sel]), 32'(held_idx));
        end
        if (trit_valid_v[sel] && trit_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_err++;
            $display("FAIL extra_trit: got trit %0d idx %0d, expected none", trit_v[sel], trit_idx_v[sel]);
          end else begin
            e = exp_q.pop_front();
            check("trit", 32'(trit_v[sel]), 32'(e.trit));
            check("idx", 32'(trit_idx_v[sel]), 32'(e.idx));
            check("last", 32'(last_v[sel]), 32'(e.last));
          end
          stall = 1'b0;
        end else if (trit_valid_v[sel]) begin
          stall     = 1'b1;
          held_trit = trit_v[sel];
          held_idx  = trit_idx_v[sel];
        end else begin
          stall = 1'b0;
        end
      end
    end
  end

  task automatic push_seq(input int cnt, input int idx0, input int n_trits);
    exp_t e;
    for (int i = 0; i < cnt; i++) begin
      e.trit = seq[i][1:0];
      e.idx  = IDX_W'(idx0 + i);
      e.last = ((idx0 + i) == (n_trits - 1));
      exp_q.push_back(e);
    end
  endtask

  task automatic check_zero(input int s, input string tag);
    check({tag, "_in_ready"}, 32'(in_ready_v[s]), 32'd0);
    check({tag, "_valid"}, 32'(trit_valid_v[s]), 32'd0);
    check({tag, "_trit"}, 32'(trit_v[s]), 32'd0);
    check({tag, "_idx"}, 32'(trit_idx_v[s]), 32'd0);
    check({tag, "_last"}, 32'(last_v[s]), 32'd0);
    check({tag, "_busy"}, 32'(busy_v[s]), 32'd0);
    check({tag, "_done"}, 32'(done_v[s]), 32'd0);
    check({tag, "_err"}, 32'(err_v[s]), 32'd0);
  endtask

  task automatic do_start(input int s);
    sel = s;
    @(posedge clk); #1 start_v[s] = 1'b1;
    @(posedge clk); #1 start_v[s] = 1'b0;
    check("start_busy", 32'(busy_v[s]), 32'd1);
    check("start_idx", 32'(trit_idx_v[s]), 32'd0);
  endtask

  task automatic feed(input logic [7:0] b);
    bit taken;
    taken = 1'b0;
    @(posedge clk); #1;
    in_byte  = b;
    in_valid = 1'b1;
    for (int i = 0; i < 200 && !taken; i++) begin
      @(negedge clk);
      if (in_ready_v[sel]) taken = 1'b1;
    end
    check("feed_accepted", 32'(taken), 32'd1);
    @(posedge clk); #1 in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(posedge clk);
    check("drain_left", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic wait_done(input int s);
    int cyc;
    bit got;
    cyc = 0;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      cyc++;
      if (done_v[s]) got = 1'b1;
    end
    check("done_seen", 32'(got), 32'd1);
    check("done_latency", 32'(cyc), 32'd1);
    @(negedge clk);
    check("done_pulse", 32'(done_v[s]), 32'd0);
    check("done_idle", 32'(busy_v[s]), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ovr_rst    = 1'b1;
    in_byte    = 8'd0;
    in_valid   = 1'b0;
    trit_ready = 1'b1;
    sel        = 2;
    for (int i = 0; i < 3; i++) start_v[i] = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_zero(2, "rst");
    @(negedge clk) ovr_rst = 1'b0;

    // 1: 10 trits from 0x00 and 0xF2 (242 = 22222 in base 3).
    do_start(0);
    seq = '{0, 0, 0, 0, 0, 2, 2, 2, 2, 2};
    push_seq(10, 0, 10);
    feed(8'h00);
    feed(8'hF2);
    wait_drain();
    wait_done(0);

    // 2: byte 100 -> 1,0,2,0,1 with one-cycle latency and reload after trit 4.
    do_start(2);
    seq = '{1, 0, 2, 0, 1, 0, 0, 0, 0, 0};
    push_seq(5, 0, 700);
    feed(8'd100);
    check("lat_valid", 32'(trit_valid_v[2]), 32'd1);
    check("lat_idx", 32'(trit_idx_v[2]), 32'd0);
    wait_drain();
    #1 check("reload_ready", 32'(in_ready_v[2]), 32'd1);

    // 3: byte 100 again under a 1,0,0,1 ready pattern.
    push_seq(5, 5, 700);
    fork
      feed(8'd100);
      begin
        logic [3:0] pat;
        pat = 4'b1001;
        for (int i = 0; i < 40; i++) begin
          @(posedge clk); #1 trit_ready = pat[i % 4];
        end
      end
    join
    trit_ready = 1'b1;
    wait_drain();

    // 4: 7 trits from bytes 100 and 5 (5 = 00012); only its low two digits appear.
    do_start(1);
    seq = '{1, 0, 2, 0, 1, 2, 1, 0, 0, 0};
    push_seq(7, 0, 7);
    feed(8'd100);
    feed(8'd5);
    wait_drain();
    #1 check("no_reload", 32'(in_ready_v[1]), 32'd0);
    wait_done(1);
    check("idle_in_ready", 32'(in_ready_v[1]), 32'd0);

    // 5: byte 250 decodes like 7 -> 1,2,0,0,0; err depends on the build.
    do_start(0);
    check("err_pre", 32'(err_v[0]), 32'd0);
    seq = '{1, 2, 0, 0, 0, 0, 0, 0, 0, 0};
    push_seq(10, 0, 10);
    feed(8'd250);
    check("err_set", 32'(err_v[0]), 32'(EXP_ERR));
    feed(8'h00);
    wait_drain();
    wait_done(0);
    check("err_sticky", 32'(err_v[0]), 32'(EXP_ERR));
    do_start(0);
    check("err_clr", 32'(err_v[0]), 32'd0);

    // 6: reset right after trit idx 3 of a fresh 700-trit run, then restart.
    @(posedge clk); #1 ovr_rst = 1'b1;
    @(negedge clk) ovr_rst = 1'b0;
    do_start(2);
    seq = '{1, 0, 2, 0, 1, 0, 0, 0, 0, 0};
    push_seq(4, 0, 700);
    feed(8'd100);
    wait_drain();
    #1 ovr_rst = 1'b1;
    #1 check_zero(2, "midrst");
    @(negedge clk) ovr_rst = 1'b0;
    do_start(2);
    seq = '{1, 0, 2, 0, 1, 1, 2, 0, 0, 0};
    push_seq(10, 0, 700);
    feed(8'd100);
    feed(8'd7);
    wait_drain();

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
